// File: rtl/simple_cpu_controller.sv
// simple_cpu_controller
// Multi-cycle control unit for the simple CPU. It owns PC and IR, fetches one
// 8-bit instruction per pass from a synchronous-read ROM, and drives the strobes
// for the register file and ALU. Every instruction takes four cycles:
// FETCH, DECODE, EXEC and WB. Execution starts from PC=0 on start and halts on a
// HALT opcode, or after PROG_LEN instructions.
//
// Optional build macro STEP_MODE_EN: when it is defined, an extra input `step`
// is present. WB then holds until step=1. The register write and the PC
// increment still happen exactly once, in the first WB cycle.
//
// ISA, IR[7:6]: 00 ADD rd+=rs | 01 SUB rd-=rs | 10 LDI rd=imm4 | 11 HALT
//   rd = IR[5:4], rs = IR[3:2], imm4 = IR[3:0]
module simple_cpu_controller #(
  parameter int PC_WIDTH = 4,
  parameter int PROG_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
`ifdef STEP_MODE_EN
  input  logic                step,
`endif
  input  logic [7:0]          imem_data,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                ir_load,
  output logic [1:0]          rf_raddr_a,
  output logic [1:0]          rf_raddr_b,
  output logic [1:0]          rf_waddr,
  output logic [1:0]          alu_op,
  output logic                alu_src_imm,
  output logic [3:0]          imm_out,
  output logic                reg_we,
  output logic                busy,
  output logic                done,
  output logic [PC_WIDTH:0]   instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LDI  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  // PC value of the last instruction in the program
  localparam logic [PC_WIDTH-1:0] PC_LAST = PC_WIDTH'(PROG_LEN - 1);
  localparam logic [PC_WIDTH:0]   CNT_MAX = '1;

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          ir;
  logic [PC_WIDTH:0]   cnt;

  logic                launch;      // start accepted from IDLE or HALT
  logic                wb_commit;   // the single cycle in which WB writes back
  logic                halt_op;     // IR holds a HALT instruction
  logic                last_instr;  // PC points at the final program slot
  logic                ir_fields;   // IR-driven outputs are valid (EXEC/WB)
  logic [1:0]          opcode;

  // Retired-instruction counter increment; it sticks at all-ones
  function automatic logic [PC_WIDTH:0] sat_inc(input logic [PC_WIDTH:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  assign opcode     = ir[7:6];
  assign halt_op    = (opcode == OP_HALT);
  assign last_instr = (pc == PC_LAST);
  assign launch     = start && ((state == S_IDLE) || (state == S_HALT));
  assign ir_fields  = (state == S_EXEC) || (state == S_WB);

`ifdef STEP_MODE_EN
  logic wb_seen;  // set while WB is held beyond its first cycle

  // Remember whether the previous cycle was already WB, so the write fires once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_seen <= 1'b0;
    end else begin
      wb_seen <= (state == S_WB);
    end
  end

  assign wb_commit = (state == S_WB) && !wb_seen;
`else
  assign wb_commit = (state == S_WB);
`endif

  // Next-state logic for the instruction sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (halt_op) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
`ifdef STEP_MODE_EN
        // The halt decision is taken on the committing cycle, regardless of step
        if (wb_commit && last_instr) begin
          state_nxt = S_HALT;
        end else if (step) begin
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_WB;
        end
`else
        if (last_instr) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_FETCH;
        end
`endif
      end
      S_HALT: begin
        if (start) begin
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Program counter: cleared on launch, advanced once per write-back.
  // It is not advanced on the last instruction, so imem_addr stays in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (launch) begin
      pc <= '0;
    end else if (wb_commit && !last_instr) begin
      pc <= pc + 1'b1;
    end
  end

  // Instruction register: captures the ROM word presented during DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= 8'h00;
    end else if (state == S_DECODE) begin
      ir <= imem_data;
    end
  end

  // Retired-instruction counter: counts write-backs plus the HALT instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (launch) begin
      cnt <= '0;
    end else if (wb_commit || ((state == S_EXEC) && halt_op)) begin
      cnt <= sat_inc(cnt);
    end
  end

  // Datapath strobes, decoded from state and IR; they are zero outside EXEC/WB
  always_comb begin
    imem_addr   = pc;
    ir_load     = (state == S_DECODE);
    rf_raddr_a  = 2'b00;
    rf_raddr_b  = 2'b00;
    rf_waddr    = 2'b00;
    alu_op      = OP_ADD;
    alu_src_imm = 1'b0;
    imm_out     = 4'h0;
    if (ir_fields) begin
      rf_raddr_a  = ir[5:4];
      rf_raddr_b  = ir[3:2];
      rf_waddr    = ir[5:4];
      alu_op      = (opcode == OP_SUB) ? OP_SUB :
                    (opcode == OP_LDI) ? OP_LDI : opcode;
      alu_src_imm = (opcode == OP_LDI);
      imm_out     = ir[3:0];
    end
    reg_we      = wb_commit;
    busy        = (state == S_FETCH) || (state == S_DECODE) ||
                  (state == S_EXEC)  || (state == S_WB);
    done        = (state == S_HALT);
    instr_count = cnt;
  end

endmodule
